match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Match sequencer for the two-player pong datapath: owns the round/match state machine, scores and timing.
//  Takes per-cycle miss pulses from the ball/paddle collision logic and a once-per-frame tick from the VGA timing.
//  Drives the ball enable, the serve strobe and the serve direction, and publishes scores and the match result.
//  Replaces ad-hoc score handling in the top-level game block. Adds serve delay, pause, post-point hold and match-over timeout.
// PARAMETERS
//  MAX_SCORE     9    points needed to win a match (1..15)
//  SERVE_FRAMES  60   frames the ball is held before a serve
//  HOLD_FRAMES   30   frames of freeze after a point before the next serve
//  OVER_FRAMES   300  frames the match-over screen stays up before auto-return to IDLE
//  TMR_W         9    frame-timer width; must hold max(SERVE,HOLD,OVER)_FRAMES
// PORTS
//  clk          in   1  system clock (single clock domain)
//  reset_n      in   1  asynchronous, active-low reset
//  run          in   1  level; ctrl-register enable, 0 forces IDLE
//  start        in   1  pulse; begin match / restart from OVER
//  pause        in   1  level; freeze play while high
//  frame_tick   in   1  1-clk pulse per video frame
//  miss_1       in   1  1-clk pulse: paddle 1 missed the ball
//  miss_2       in   1  1-clk pulse: paddle 2 missed the ball
//  ball_en      out  1  ball motion enable (high only in PLAY)
//  serve        out  1  1-clk strobe: recentre ball and launch
//  serve_dir    out  1  launch direction: 0 = toward player 1 (left), 1 = toward player 2
//  score        out  8  {score_1[3:0], score_2[3:0]}, binary
//  match_over   out  1  high in OVER
//  winner       out  1  0 = player 1, 1 = player 2; valid while match_over
//  state        out  3  current state code, for debug/overlay
// BEHAVIOUR
//  Reset values: state=IDLE, score=0, ball_en=0, serve=0, serve_dir=0, match_over=0, winner=0, timer=0.
//  All outputs are registered or decoded from the state register. No combinational input->output paths.
//  States: IDLE, SERVE, PLAY, PAUSE, POINT, HOLD, OVER.
//  run==0 in any state: IDLE on the next clk. Scores are kept; serve is not asserted. run takes priority over every other input.
//  IDLE: start -> SERVE. Scores clear to 0, timer loads SERVE_FRAMES, serve_dir=1.
//  SERVE / HOLD / OVER: timer decrements on each frame_tick. Exit is taken in the cycle the timer == 0.
//    A timer loaded with 0 therefore exits after one clk.
//  SERVE, timer==0 -> PLAY. serve=1 for exactly the first PLAY cycle. ball_en goes high in that same cycle.
//  PLAY priority, highest first:
//    miss_1 & miss_2 in the same cycle -> HOLD. No score change; serve_dir unchanged.
//    miss_1 -> POINT with scorer=P2. serve_dir:=0 (next ball goes to the conceding player).
//    miss_2 -> POINT with scorer=P1. serve_dir:=1.
//    pause -> PAUSE.
//  PAUSE: ball_en=0, miss_* ignored. pause low -> PLAY with no serve strobe (ball resumes in place).
//  POINT (exactly 1 clk): scorer's count +1.
//    New value == MAX_SCORE -> OVER: winner=scorer, timer:=OVER_FRAMES.
//    Otherwise -> HOLD: timer:=HOLD_FRAMES.
//  HOLD, timer==0 -> SERVE: timer:=SERVE_FRAMES.
//  OVER: scores held for display.
//    start -> SERVE with scores cleared (start wins over a simultaneous timer expiry).
//    timer==0 -> IDLE with scores cleared.
//  Scores never exceed MAX_SCORE. There is no wrap: an increment is only issued in POINT.
//  frame_tick and miss_* arriving outside their consuming states are dropped, not queued.
//  Reset asserted mid-match: asynchronous return to reset values; ball_en drops immediately.
// STRUCTURE
//  Shared header pong_defs.vh: state codes (3-bit localparams), PLAYER_1/PLAYER_2, SCORE_W=4.
//  ball_ctrl and the overlay logic consume the same state codes from that header.
//  Sub-module frame_timer (TMR_W):
//    Ports: load, load_val, tick, zero.
//    Loadable down-counter that decrements only on tick and saturates at 0.
//  FSM and score registers stay in match_ctrl.
// TESTING (TB uses small params: SERVE=2, HOLD=1, OVER=3, MAX_SCORE=3, frame_tick every 4 clk)
//  Reset then start -> ball_en=0 for 2 ticks; serve=1 for one clk as ball_en rises; serve_dir=1.
//  PLAY, miss_2 -> one POINT clk, score=8'h10, HOLD 1 tick, SERVE 2 ticks; serve_dir=1 at the next serve.
//  miss_1 and miss_2 in the same clk -> score unchanged, HOLD then re-serve.
//  Three miss_1 pulses -> score=8'h03, match_over=1, winner=1.
//    3 ticks later: IDLE, score=0.
//    Repeat with start during OVER -> SERVE, score=0.
//  pause high in PLAY with a miss_1 during PAUSE -> ball_en=0, score unchanged; release -> PLAY, no serve strobe.
//  run low mid-SERVE -> IDLE next clk, score kept. reset_n pulse mid-PLAY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/match_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// match_ctrl_pkg
//  Shared definitions for the pong match sequencer and its consumers
//  (ball control and the score/state overlay decode the same state codes).
//  Contents:
//    state_t      3-bit match state codes
//    PLAYER_1/2   player identifiers used for scorer / winner / serve side
//    SCORE_W      width of one player's score counter
//    timed_state  true for the states whose exit is governed by the frame timer
// -----------------------------------------------------------------------------
package match_ctrl_pkg;

    localparam int SCORE_W = 4;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_HOLD  = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    // States in which frame ticks count down the frame timer.
    function automatic logic timed_state(input state_t s);
        return (s == ST_SERVE) || (s == ST_HOLD) || (s == ST_OVER);
    endfunction

endpackage

// File: rtl/match_ctrl_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
//  Loadable down-counter measured in video frames. Decrements once per tick
//  and saturates at zero; a load takes priority over a simultaneous tick.
//  Ports:
//    clk       system clock
//    reset_n   asynchronous active-low reset (count clears to 0)
//    load      load load_val into the counter this clock
//    load_val  value to load (TMR_W bits)
//    tick      decrement enable (one per frame, already gated by the caller)
//    zero      high while the count is 0
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int TMR_W = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [TMR_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - TMR_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/match_ctrl.sv
// -----------------------------------------------------------------------------
// match_ctrl
//  Round/match sequencer for the two-player pong datapath. Owns the match
//  state machine, both score counters and the frame-based delays (serve
//  delay, post-point hold, match-over timeout).
//  Ports:
//    clk         system clock
//    reset_n     asynchronous active-low reset
//    run         level, 0 forces IDLE (highest priority)
//    start       pulse, begin a match / restart from OVER
//    pause       level, freeze play while high
//    frame_tick  one-clock pulse per video frame
//    miss_1      one-clock pulse, paddle 1 missed the ball
//    miss_2      one-clock pulse, paddle 2 missed the ball
//    ball_en     ball motion enable (PLAY only)
//    serve       one-clock strobe in the first PLAY cycle after a serve delay
//    serve_dir   launch direction, 0 toward player 1, 1 toward player 2
//    score       {score_1, score_2}, binary
//    match_over  high in OVER
//    winner      winning player, valid while match_over
//    state       current state code
//  Every output comes from a register or a decode of the state register.
// -----------------------------------------------------------------------------
module match_ctrl
    import match_ctrl_pkg::*;
#(
    parameter int MAX_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int HOLD_FRAMES  = 30,
    parameter int OVER_FRAMES  = 300,
    parameter int TMR_W        = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       start,
    input  logic       pause,
    input  logic       frame_tick,
    input  logic       miss_1,
    input  logic       miss_2,
    output logic       ball_en,
    output logic       serve,
    output logic       serve_dir,
    output logic [7:0] score,
    output logic       match_over,
    output logic       winner,
    output logic [2:0] state
);

    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] score_1_reg, score_1_next;
    logic [SCORE_W-1:0] score_2_reg, score_2_next;
    logic [SCORE_W-1:0] point_score;
    logic               serve_reg, serve_next;
    logic               serve_dir_reg, serve_dir_next;
    logic               winner_reg, winner_next;
    logic               scorer_reg, scorer_next;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic               tmr_tick;
    logic               tmr_zero;

    // Frame ticks outside SERVE/HOLD/OVER are dropped rather than queued.
    assign tmr_tick = frame_tick && timed_state(state_reg);

    frame_timer #(
        .TMR_W(TMR_W)
    ) u_frame_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .tick    (tmr_tick),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            score_1_reg   <= '0;
            score_2_reg   <= '0;
            serve_reg     <= 1'b0;
            serve_dir_reg <= 1'b0;
            winner_reg    <= PLAYER_1;
            scorer_reg    <= PLAYER_1;
        end else begin
            state_reg     <= state_next;
            score_1_reg   <= score_1_next;
            score_2_reg   <= score_2_next;
            serve_reg     <= serve_next;
            serve_dir_reg <= serve_dir_next;
            winner_reg    <= winner_next;
            scorer_reg    <= scorer_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        score_1_next   = score_1_reg;
        score_2_next   = score_2_reg;
        serve_dir_next = serve_dir_reg;
        winner_next    = winner_reg;
        scorer_next    = scorer_reg;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;
        point_score    = '0;

        if (!run) begin
            // Scores are kept so the overlay can still show them.
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next     = ST_SERVE;
                        score_1_next   = '0;
                        score_2_next   = '0;
                        serve_dir_next = PLAYER_2;
                        tmr_load       = 1'b1;
                        tmr_load_val   = TMR_W'(SERVE_FRAMES);
                    end
                end

                ST_SERVE: begin
                    if (tmr_zero) begin
                        state_next = ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (miss_1 && miss_2) begin
                        // Simultaneous misses: no point awarded, replay the serve.
                        state_next   = ST_HOLD;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(HOLD_FRAMES);
                    end else if (miss_1) begin
                        // Next ball goes to the player who conceded.
                        state_next     = ST_POINT;
                        scorer_next    = PLAYER_2;
                        serve_dir_next = PLAYER_1;
                    end else if (miss_2) begin
                        state_next     = ST_POINT;
                        scorer_next    = PLAYER_1;
                        serve_dir_next = PLAYER_2;
                    end else if (pause) begin
                        state_next = ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (!pause) begin
                        state_next = ST_PLAY;
                    end
                end

                ST_POINT: begin
                    // The only place a score increments; the win check on the
                    // new value keeps scores from ever passing MAX_SCORE.
                    point_score = ((scorer_reg == PLAYER_1) ? score_1_reg : score_2_reg)
                                  + SCORE_W'(1);
                    if (scorer_reg == PLAYER_1) begin
                        score_1_next = point_score;
                    end else begin
                        score_2_next = point_score;
                    end
                    tmr_load = 1'b1;
                    if (point_score == SCORE_W'(MAX_SCORE)) begin
                        state_next   = ST_OVER;
                        winner_next  = scorer_reg;
                        tmr_load_val = TMR_W'(OVER_FRAMES);
                    end else begin
                        state_next   = ST_HOLD;
                        tmr_load_val = TMR_W'(HOLD_FRAMES);
                    end
                end

                ST_HOLD: begin
                    if (tmr_zero) begin
                        state_next   = ST_SERVE;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(SERVE_FRAMES);
                    end
                end

                ST_OVER: begin
                    // A restart request beats the timeout in the same cycle.
                    if (start) begin
                        state_next     = ST_SERVE;
                        score_1_next   = '0;
                        score_2_next   = '0;
                        serve_dir_next = PLAYER_2;
                        tmr_load       = 1'b1;
                        tmr_load_val   = TMR_W'(SERVE_FRAMES);
                    end else if (tmr_zero) begin
                        state_next   = ST_IDLE;
                        score_1_next = '0;
                        score_2_next = '0;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Strobe lands in the first PLAY cycle; a resume from PAUSE never serves.
    assign serve_next = (state_reg == ST_SERVE) && (state_next == ST_PLAY);

    assign ball_en    = (state_reg == ST_PLAY);
    assign match_over = (state_reg == ST_OVER);
    assign serve      = serve_reg;
    assign serve_dir  = serve_dir_reg;
    assign winner     = winner_reg;
    assign score      = {score_1_reg, score_2_reg};
    assign state      = state_reg;

endmodule

// File: tb/tb_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_ctrl
//  Self-checking bench for match_ctrl with small timing parameters
//  (SERVE=2, HOLD=1, OVER=3 frames, MAX_SCORE=3, one frame tick every 4 clks).
//  Outputs are packed into one 16-bit observation word:
//    [15:13] state  [12:5] score  [4] ball_en  [3] serve  [2] serve_dir
//    [1] match_over [0] winner
// -----------------------------------------------------------------------------
module tb_match_ctrl;
    import match_ctrl_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic       start;
    logic       pause;
    logic       frame_tick;
    logic       miss_1;
    logic       miss_2;
    logic       ball_en;
    logic       serve;
    logic       serve_dir;
    logic [7:0] score;
    logic       match_over;
    logic       winner;
    logic [2:0] state;

    logic [15:0] obs;
    assign obs = {state, score, ball_en, serve, serve_dir, match_over, winner};

    match_ctrl #(
        .MAX_SCORE   (3),
        .SERVE_FRAMES(2),
        .HOLD_FRAMES (1),
        .OVER_FRAMES (3),
        .TMR_W       (9)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .start     (start),
        .pause     (pause),
        .frame_tick(frame_tick),
        .miss_1    (miss_1),
        .miss_2    (miss_2),
        .ball_en   (ball_en),
        .serve     (serve),
        .serve_dir (serve_dir),
        .score     (score),
        .match_over(match_over),
        .winner    (winner),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock frame tick every 4 clocks, changed just after the rising edge.
    initial begin
        int phase;
        phase = 0;
        frame_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase == 3) ? 0 : phase + 1;
            frame_tick = (phase == 3);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [15:0] M_ALL    = 16'hFFFF;
    localparam logic [15:0] M_NO_WIN = 16'hFFFE;
    localparam logic [15:0] M_NO_DW  = 16'hFFFA;  // ignore serve_dir and winner
    localparam logic [15:0] M_HEAD   = 16'hFFF8;  // state, score, ball_en, serve

    typedef enum int {A_NONE, A_START, A_MISS1, A_MISS2, A_BOTH} act_t;

    typedef struct {
        act_t        act;
        logic [2:0]  wait_st;
        logic [15:0] exp;
        logic [15:0] mask;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
        logic [15:0] mask;
    } sb_t;

    vec_t vt[$];
    sb_t  sb_q[$];
    int   n_vec;
    int   n_err;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic [7:0] sc,
                                       input logic be, input logic sv, input logic dir,
                                       input logic mo, input logic win);
        return {st, sc, be, sv, dir, mo, win};
    endfunction

    task automatic sb_push(input string n, input logic [15:0] e, input logic [15:0] m);
        sb_t s;
        s.name = n;
        s.exp  = e;
        s.mask = m;
        sb_q.push_back(s);
    endtask

    task automatic sb_pop_check(input logic [15:0] act);
        sb_t s;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
        end else begin
            s = sb_q.pop_front();
            if ((act & s.mask) !== (s.exp & s.mask)) begin
                n_err++;
                $display("FAIL %s: got %h required %h (mask %h)", s.name, act, s.exp, s.mask);
            end else begin
                $display("ok   %s: %h", s.name, act & s.mask);
            end
        end
    endtask

    task automatic sb_pop_timeout(input logic [2:0] want);
        sb_t s;
        n_vec++;
        n_err++;
        s.name = "scoreboard_empty";
        if (sb_q.size() != 0) s = sb_q.pop_front();
        $display("FAIL %s: timeout, state %0d required state %0d", s.name, state, want);
    endtask

    // Called at a falling edge; drives a one-clock pulse and returns at the next one.
    task automatic drive(input act_t a);
        if (a != A_NONE) begin
            start  = (a == A_START);
            miss_1 = (a == A_MISS1) || (a == A_BOTH);
            miss_2 = (a == A_MISS2) || (a == A_BOTH);
            @(negedge clk);
            start  = 1'b0;
            miss_1 = 1'b0;
            miss_2 = 1'b0;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (state == st) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v);
        bit ok;
        sb_push(v.name, v.exp, v.mask);
        drive(v.act);
        wait_state(v.wait_st, ok);
        if (ok) sb_pop_check(obs);
        else    sb_pop_timeout(v.wait_st);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(vt[i]);
    endtask

    task automatic add_vec(input act_t a, input logic [2:0] st, input logic [15:0] e,
                           input logic [15:0] m, input string n);
        vec_t v;
        v.act     = a;
        v.wait_st = st;
        v.exp     = e;
        v.mask    = m;
        v.name    = n;
        vt.push_back(v);
    endtask

    // Counts frame ticks seen while the DUT stays in st; returns at the exit edge.
    task automatic count_ticks(input logic [2:0] st, output int ticks, output int be_high);
        ticks   = 0;
        be_high = 0;
        for (int c = 0; c < 200; c++) begin
            if (state != st) break;
            if (frame_tick) ticks++;
            if (ball_en) be_high++;
            @(negedge clk);
        end
    endtask

    initial begin
        int ticks;
        int be_high;
        bit ok;

        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        run     = 1'b1;
        start   = 1'b0;
        pause   = 1'b0;
        miss_1  = 1'b0;
        miss_2  = 1'b0;

        // Rally table, starting from PLAY with score 00 after the first serve.
        add_vec(A_MISS2, ST_POINT, mk(ST_POINT, 8'h00, 0, 0, 1, 0, 0), M_ALL,    "miss2_point");
        add_vec(A_NONE,  ST_HOLD,  mk(ST_HOLD,  8'h10, 0, 0, 1, 0, 0), M_ALL,    "miss2_hold");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h10, 1, 1, 1, 0, 0), M_ALL,    "miss2_reserve");
        add_vec(A_BOTH,  ST_HOLD,  mk(ST_HOLD,  8'h10, 0, 0, 1, 0, 0), M_ALL,    "both_hold_dir1");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h10, 1, 1, 1, 0, 0), M_ALL,    "both_reserve");
        add_vec(A_MISS1, ST_POINT, mk(ST_POINT, 8'h10, 0, 0, 0, 0, 0), M_ALL,    "miss1_point");
        add_vec(A_NONE,  ST_HOLD,  mk(ST_HOLD,  8'h11, 0, 0, 0, 0, 0), M_ALL,    "miss1_hold");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h11, 1, 1, 0, 0, 0), M_ALL,    "miss1_reserve");
        add_vec(A_BOTH,  ST_HOLD,  mk(ST_HOLD,  8'h11, 0, 0, 0, 0, 0), M_ALL,    "both_hold_dir0");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h11, 1, 1, 0, 0, 0), M_ALL,    "both_reserve2");
        add_vec(A_MISS1, ST_HOLD,  mk(ST_HOLD,  8'h12, 0, 0, 0, 0, 0), M_ALL,    "p2_second");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h12, 1, 1, 0, 0, 0), M_ALL,    "p2_second_serve");
        add_vec(A_MISS1, ST_OVER,  mk(ST_OVER,  8'h13, 0, 0, 0, 1, 1), M_ALL,    "p2_wins");
        // Second match from IDLE, straight to a 0:3 win.
        add_vec(A_START, ST_PLAY,  mk(ST_PLAY,  8'h00, 1, 1, 1, 0, 0), M_NO_WIN, "m2_start");
        add_vec(A_MISS1, ST_HOLD,  mk(ST_HOLD,  8'h01, 0, 0, 0, 0, 0), M_NO_WIN, "m2_pt1");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h01, 1, 1, 0, 0, 0), M_NO_WIN, "m2_serve1");
        add_vec(A_MISS1, ST_HOLD,  mk(ST_HOLD,  8'h02, 0, 0, 0, 0, 0), M_NO_WIN, "m2_pt2");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h02, 1, 1, 0, 0, 0), M_NO_WIN, "m2_serve2");
        add_vec(A_MISS1, ST_OVER,  mk(ST_OVER,  8'h03, 0, 0, 0, 1, 1), M_ALL,    "m2_p2_wins");
        // After restart from OVER.
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h00, 1, 1, 0, 0, 0), M_NO_DW,  "m3_play");
        add_vec(A_MISS2, ST_HOLD,  mk(ST_HOLD,  8'h10, 0, 0, 1, 0, 0), M_NO_WIN, "m3_pt");
        add_vec(A_NONE,  ST_PLAY,  mk(ST_PLAY,  8'h10, 1, 1, 1, 0, 0), M_NO_WIN, "m3_serve");
        add_vec(A_MISS2, ST_SERVE, mk(ST_SERVE, 8'h20, 0, 0, 1, 0, 0), M_NO_WIN, "m3_to_serve");
        add_vec(A_START, ST_PLAY,  mk(ST_PLAY,  8'h00, 1, 1, 1, 0, 0), M_NO_WIN, "m4_start");
        add_vec(A_MISS2, ST_PLAY,  mk(ST_PLAY,  8'h10, 1, 1, 1, 0, 0), M_NO_WIN, "m4_serve");

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        sb_push("reset_state", mk(ST_IDLE, 8'h00, 0, 0, 0, 0, 0), M_ALL);
        sb_pop_check(obs);

        // First serve: two frames held, then one serve strobe as ball_en rises.
        drive(A_START);
        sb_push("serve_ticks", 16'd2, M_ALL);
        sb_push("ball_en_in_serve", 16'd0, M_ALL);
        count_ticks(ST_SERVE, ticks, be_high);
        sb_pop_check(16'(ticks));
        sb_pop_check(16'(be_high));
        sb_push("first_play", mk(ST_PLAY, 8'h00, 1, 1, 1, 0, 0), M_ALL);
        sb_pop_check(obs);
        @(negedge clk);
        sb_push("serve_one_clk", mk(ST_PLAY, 8'h00, 1, 0, 1, 0, 0), M_ALL);
        sb_pop_check(obs);

        run_range(0, 12);

        // OVER times out after three frames and clears the scores.
        sb_push("over_ticks", 16'd3, M_ALL);
        sb_push("over_to_idle", mk(ST_IDLE, 8'h00, 0, 0, 0, 0, 0), M_NO_WIN);
        count_ticks(ST_OVER, ticks, be_high);
        sb_pop_check(16'(ticks));
        sb_pop_check(obs);

        run_range(13, 18);

        // start while in OVER restarts the match directly.
        sb_push("over_restart", mk(ST_SERVE, 8'h00, 0, 0, 0, 0, 0), M_NO_DW);
        drive(A_START);
        sb_pop_check(obs);

        run_range(19, 21);

        // Pause: misses ignored, resume without a serve strobe.
        pause = 1'b1;
        @(negedge clk);
        sb_push("pause_enter", mk(ST_PAUSE, 8'h10, 0, 0, 0, 0, 0), M_HEAD);
        sb_pop_check(obs);
        drive(A_MISS1);
        @(negedge clk);
        sb_push("pause_miss_ignored", mk(ST_PAUSE, 8'h10, 0, 0, 0, 0, 0), M_HEAD);
        sb_pop_check(obs);
        pause = 1'b0;
        @(negedge clk);
        sb_push("pause_release", mk(ST_PLAY, 8'h10, 1, 0, 1, 0, 0), M_NO_WIN);
        sb_pop_check(obs);

        run_range(22, 22);

        // run low mid-SERVE: IDLE on the next clock, score kept, no strobe.
        run = 1'b0;
        @(negedge clk);
        sb_push("run_low", mk(ST_IDLE, 8'h20, 0, 0, 1, 0, 0), M_NO_WIN);
        sb_pop_check(obs);
        @(negedge clk);
        sb_push("run_low_hold", mk(ST_IDLE, 8'h20, 0, 0, 1, 0, 0), M_NO_WIN);
        sb_pop_check(obs);
        run = 1'b1;
        @(negedge clk);

        run_range(23, 24);

        // Asynchronous reset between clock edges mid-PLAY.
        wait_state(ST_PLAY, ok);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        sb_push("async_reset", mk(ST_IDLE, 8'h00, 0, 0, 0, 0, 0), M_ALL);
        sb_pop_check(obs);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sb_push("post_reset_idle", mk(ST_IDLE, 8'h00, 0, 0, 0, 0, 0), M_ALL);
        sb_pop_check(obs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
